// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester front end for a single shared ALU.
//   One transaction is in flight at a time. The FSM walks IDLE -> EXEC -> RESP.
//   - IDLE: a request is granted and its operands are latched.
//   - EXEC: the latched operands drive the ALU, and the ALU result is captured.
//   - RESP: the captured result is held until the granted requester takes it.
//
// Ports:
//   clk, rst_n             clock; synchronous active-low reset
//   reqN_valid/ready       request handshake, N = 0, 1
//   reqN_op/a/b            opcode and operands for requester N
//   respN_valid/ready      response handshake, N = 0, 1
//   resp_data              shared result bus
//   alu_ctrl/alu_a/alu_b   registered operands sent to the shared ALU
//   alu_result             combinational result returned by the ALU
//   busy                   high whenever the FSM is not in IDLE
//
// Build option:
//   ALU_ARB_RR_EN  Define this macro to get round-robin arbitration.
//                  When it is not defined, requester 0 has fixed priority.
module alu_arbiter #(
   parameter int W   = 32,
   parameter int OPW = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           req0_valid,
   output logic           req0_ready,
   input  logic [OPW-1:0] req0_op,
   input  logic [W-1:0]   req0_a,
   input  logic [W-1:0]   req0_b,
   input  logic           req1_valid,
   output logic           req1_ready,
   input  logic [OPW-1:0] req1_op,
   input  logic [W-1:0]   req1_a,
   input  logic [W-1:0]   req1_b,
   output logic           resp0_valid,
   input  logic           resp0_ready,
   output logic           resp1_valid,
   input  logic           resp1_ready,
   output logic [W-1:0]   resp_data,
   output logic [OPW-1:0] alu_ctrl,
   output logic [W-1:0]   alu_a,
   output logic [W-1:0]   alu_b,
   input  logic [W-1:0]   alu_result,
   output logic           busy
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

   state_e         state_q, state_d;
   logic [OPW-1:0] op_q, op_d;
   logic [W-1:0]   a_q, a_d;
   logic [W-1:0]   b_q, b_d;
   logic [W-1:0]   data_q, data_d;
   logic           gnt_q, gnt_d;      // index of the requester being served
   logic           gnt_idx;           // requester picked this cycle while in IDLE
   logic           any_valid;
   logic           in_idle;
   logic           req_fire;
   logic           resp_fire;

`ifdef ALU_ARB_RR_EN
   logic           last_q, last_d;
`endif

   assign any_valid = req0_valid | req1_valid;
   // Gate on rst_n so that no handshake can look live during a reset cycle.
   assign in_idle   = (state_q == IDLE) && rst_n;
   assign req_fire  = in_idle && any_valid;

`ifdef ALU_ARB_RR_EN
   // On contention, grant the requester that was not served last.
   // With a single valid requester, grant that requester.
   assign gnt_idx = (req0_valid && req1_valid) ? ~last_q : req1_valid;
`else
   // Fixed priority: requester 1 wins only when requester 0 is idle.
   assign gnt_idx = ~req0_valid;
`endif

   assign req0_ready  = req_fire && !gnt_idx;
   assign req1_ready  = req_fire &&  gnt_idx;
   assign resp0_valid = (state_q == RESP) && rst_n && !gnt_q;
   assign resp1_valid = (state_q == RESP) && rst_n &&  gnt_q;
   assign resp_fire   = (resp0_valid && resp0_ready) || (resp1_valid && resp1_ready);
   assign busy        = (state_q != IDLE) && rst_n;

   // The ALU is fed from registers only, so requester inputs never reach it directly.
   assign alu_ctrl  = op_q;
   assign alu_a     = a_q;
   assign alu_b     = b_q;
   assign resp_data = data_q;

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      data_d  = data_q;
      gnt_d   = gnt_q;
`ifdef ALU_ARB_RR_EN
      last_d  = last_q;
`endif
      case (state_q)
         IDLE: begin
            if (req_fire) begin
               op_d    = gnt_idx ? req1_op : req0_op;
               a_d     = gnt_idx ? req1_a  : req0_a;
               b_d     = gnt_idx ? req1_b  : req0_b;
               gnt_d   = gnt_idx;
`ifdef ALU_ARB_RR_EN
               last_d  = gnt_idx;
`endif
               state_d = EXEC;
            end
         end
         EXEC: begin
            data_d  = alu_result;
            state_d = RESP;
         end
         RESP: begin
            if (resp_fire) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         data_q  <= '0;
         gnt_q   <= 1'b0;
`ifdef ALU_ARB_RR_EN
         // Starting from 1 gives requester 0 the first contended grant.
         last_q  <= 1'b1;
`endif
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         data_q  <= data_d;
         gnt_q   <= gnt_d;
`ifdef ALU_ARB_RR_EN
         last_q  <= last_d;
`endif
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter. Stimulus pushes the expected {grant, data}
// pair when a request is accepted. A negedge monitor pops the pair on each
// response handshake and compares it with the DUT output.
// Opcode encoding used by the bench ALU model: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL.
module tb_alu_arbiter;
   localparam int W = 32;
   localparam int OPW = 4;
   localparam logic [OPW-1:0] ADD = 4'd0, SUB = 4'd1, OR_ = 4'd3, XOR_ = 4'd4, SLL = 4'd5;

   typedef struct {
      logic        g;
      logic [31:0] d;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   logic req0_valid, req0_ready, req1_valid, req1_ready;
   logic [OPW-1:0] req0_op, req1_op, alu_ctrl;
   logic [W-1:0] req0_a, req0_b, req1_a, req1_b, resp_data, alu_a, alu_b, alu_result;
   logic resp0_valid, resp0_ready, resp1_valid, resp1_ready, busy;

   int checks = 0;
   int errors = 0;
   exp_t q[$];

   always #5 clk = ~clk;

   alu_arbiter #(.W(W), .OPW(OPW)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
      .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
      .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
      .resp_data(resp_data), .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b),
      .alu_result(alu_result), .busy(busy)
   );

   // Combinational model of the shared ALU.
   always_comb begin
      alu_result = '0;
      case (alu_ctrl)
         4'd0: alu_result = alu_a + alu_b;
         4'd1: alu_result = alu_a - alu_b;
         4'd2: alu_result = alu_a & alu_b;
         4'd3: alu_result = alu_a | alu_b;
         4'd4: alu_result = alu_a ^ alu_b;
         4'd5: alu_result = alu_a << alu_b[4:0];
         default: alu_result = '0;
      endcase
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", nm, act, exp);
      end
   endtask

   // Monitor: every response handshake must match the oldest expected entry.
   always @(negedge clk) begin
      if (rst_n) begin
         if (resp0_valid || resp1_valid) check("resp_onehot", 32'(resp0_valid & resp1_valid), 0);
         if ((resp0_valid && resp0_ready) || (resp1_valid && resp1_ready)) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_resp got resp0_valid=%0b resp1_valid=%0b data=%0h want none",
                        resp0_valid, resp1_valid, resp_data);
            end else begin
               exp_t e;
               e = q.pop_front();
               check("resp_grant", 32'(resp1_valid), 32'(e.g));
               check("resp_data", resp_data, e.d);
            end
         end
      end
   end

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // Wait for requester n to be accepted. Optionally push the expected
   // response, then drop valid after the fire edge.
   task automatic wait_ready(input int n, input bit push, input logic [31:0] d);
      bit seen = 0;
      for (int c = 0; c < 20 && !seen; c++) begin
         @(negedge clk);
         seen = (n == 1) ? req1_ready : req0_ready;
      end
      check("ready_seen", 32'(seen), 1);
      if (seen && push) begin
         exp_t e;
         e.g = (n == 1);
         e.d = d;
         q.push_back(e);
      end
      @(posedge clk);
      #1;
      if (n == 1) req1_valid = 1'b0;
      else req0_valid = 1'b0;
   endtask

   task automatic drain();
      for (int c = 0; c < 30 && q.size() != 0; c++) @(negedge clk);
      check("drain", q.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1);
   end

   initial begin
      rst_n = 0;
      req0_valid = 1; req0_op = ADD; req0_a = 5; req0_b = 7;
      req1_valid = 0; req1_op = 0; req1_a = 0; req1_b = 0;
      resp0_ready = 1; resp1_ready = 1;

      // Reset state: ready stays low even though req0_valid is high.
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_req0_ready", 32'(req0_ready), 0);
      check("rst_req1_ready", 32'(req1_ready), 0);
      check("rst_resp_valid", 32'(resp0_valid | resp1_valid), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_resp_data", resp_data, 0);
      check("rst_alu_a", alu_a, 0);
      check("rst_alu_ctrl", 32'(alu_ctrl), 0);

      // ADD 5 + 7 on req0: fire at N, response at N+2.
      @(posedge clk);
      #1 rst_n = 1;
      @(negedge clk);
      check("add_fire_ready0", 32'(req0_ready), 1);
      check("add_fire_ready1", 32'(req1_ready), 0);
      begin
         exp_t e;
         e.g = 0;
         e.d = 12;
         q.push_back(e);
      end
      @(posedge clk);
      #1 req0_valid = 0;
      @(negedge clk);
      check("add_exec_busy", 32'(busy), 1);
      check("add_exec_resp0", 32'(resp0_valid), 0);
      check("add_exec_alu_a", alu_a, 5);
      check("add_exec_alu_b", alu_b, 7);
      check("add_exec_ctrl", 32'(alu_ctrl), 32'(ADD));
      @(negedge clk);
      check("add_n2_resp0", 32'(resp0_valid), 1);
      check("add_n2_resp1", 32'(resp1_valid), 0);
      @(negedge clk);
      check("add_n3_busy", 32'(busy), 0);
      check("add_hold_alu_a", alu_a, 5);
      drain();

      // Both requesters valid: SUB 10-3 on req0, XOR F0^FF on req1.
      do_reset();
      req0_valid = 1; req0_op = SUB; req0_a = 10; req0_b = 3;
      req1_valid = 1; req1_op = XOR_; req1_a = 32'hF0; req1_b = 32'hFF;
      begin
         logic tb_last = 1'b1;
         logic exp_g;
         int fires = 0;
         for (int c = 0; c < 60 && fires < 4; c++) begin
            @(negedge clk);
            if (busy) begin
               check("rdy_while_busy", 32'(req0_ready | req1_ready), 0);
            end else begin
`ifdef ALU_ARB_RR_EN
               exp_g = ~tb_last;
`else
               exp_g = 1'b0;
`endif
               check("both_ready0", 32'(req0_ready), 32'(!exp_g));
               check("both_ready1", 32'(req1_ready), 32'(exp_g));
               begin
                  exp_t e;
                  e.g = exp_g;
                  e.d = exp_g ? 32'h0F : 32'd7;
                  q.push_back(e);
               end
               tb_last = exp_g;
               fires++;
            end
         end
         check("both_fires", fires, 4);
      end
      @(posedge clk);
      #1 req0_valid = 0;
      req1_valid = 0;
      drain();

      // SLL 1 << 4 on req1 with a stalled response; req0 waits meanwhile.
      @(posedge clk);
      #1 resp1_ready = 0;
      req1_valid = 1; req1_op = SLL; req1_a = 1; req1_b = 4;
      wait_ready(1, 1, 16);
      req0_valid = 1; req0_op = ADD; req0_a = 2; req0_b = 3;
      begin
         bit seen = 0;
         for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            seen = resp1_valid;
         end
         check("sll_resp_seen", 32'(seen), 1);
      end
      for (int k = 0; k < 5; k++) begin
         check("sll_hold_valid", 32'(resp1_valid), 1);
         check("sll_hold_data", resp_data, 16);
         check("sll_stall_ready0", 32'(req0_ready), 0);
         @(negedge clk);
      end
      @(posedge clk);
      #1 resp1_ready = 1;
      wait_ready(0, 1, 5);
      drain();

      // Reset during EXEC discards the request.
      @(posedge clk);
      #1 req0_valid = 1; req0_op = ADD; req0_a = 5; req0_b = 7;
      wait_ready(0, 0, 0);
      rst_n = 0;
      @(negedge clk);
      check("midrst_ready", 32'(req0_ready | req1_ready), 0);
      check("midrst_busy", 32'(busy), 0);
      @(posedge clk);
      #1 rst_n = 1;
      @(negedge clk);
      check("postrst_busy", 32'(busy), 0);
      check("postrst_data", resp_data, 0);
      check("postrst_alu_a", alu_a, 0);
      for (int k = 0; k < 4; k++) begin
         check("postrst_no_resp", 32'(resp0_valid | resp1_valid), 0);
         @(negedge clk);
      end
      @(posedge clk);
      #1 req1_valid = 1; req1_op = OR_; req1_a = 32'h3; req1_b = 32'hC;
      wait_ready(1, 1, 32'hF);
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
